adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 111 +++++++++++
 tb/tb_adder_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end to a single shared N-bit adder.
// Each operation walks IDLE -> LOAD -> OUT: capture, add, present result.
module adder_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         valid,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         rid,
  output logic         busy
);

  localparam int unsigned SUM_W = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               take;
  logic               winner;
  logic               last;
  logic [N-1:0]       op_a;
  logic [N-1:0]       op_b;
  logic               op_id;
  logic [SUM_W-1:0]   sum;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = LOAD;
          take      = 1'b1;
        end
      end
      LOAD:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The one shared adder, carry kept in the extra bit.
  assign sum = SUM_W'(op_a) + SUM_W'(op_b);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      y     <= '0;
      cout  <= 1'b0;
      rid   <= 1'b0;
      last  <= 1'b1;
      op_a  <= '0;
      op_b  <= '0;
      op_id <= 1'b0;
    end else begin
      gnt0  <= take && !winner;
      gnt1  <= take && winner;
      valid <= (state == LOAD);
      busy  <= (state_nxt != IDLE);
      if (take) begin
        op_a  <= winner ? a1 : a0;
        op_b  <= winner ? b1 : b0;
        op_id <= winner;
        last  <= winner;
      end
      if (state == LOAD) begin
        y    <= sum[N-1:0];
        cout <= sum[N];
        rid  <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: expected results queued at stimulus time,
// popped and compared on every valid pulse.
module tb_adder_arbiter;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset_n;
  logic         req0;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic         req1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         gnt0;
  logic         gnt1;
  logic         valid;
  logic [N-1:0] y;
  logic         cout;
  logic         rid;
  logic         busy;

  typedef struct {
    logic [N-1:0] y;
    logic         cout;
    logic         rid;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  adder_arbiter #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .valid   (valid),
    .y       (y),
    .cout    (cout),
    .rid     (rid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [N-1:0] ey, input logic ec, input logic er);
    exp_t e;
    e.y = ey;
    e.cout = ec;
    e.rid = er;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Result monitor and grant-exclusivity check, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("gnt_excl", N'(gnt0 & gnt1), N'(0));
      if (valid === 1'b1) begin
        vcyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_valid", N'(1), N'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y", y, e.y);
          chk("cout", N'(cout), N'(e.cout));
          chk("rid", N'(rid), N'(e.rid));
        end
      end
    end
  end

  initial begin
    cyc = 0;
    n_cmp = 0;
    n_err = 0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset values
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_valid", N'(valid), N'(0));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_gnt", N'({gnt1, gnt0}), N'(0));
    chk("rst_y", y, N'(0));
    chk("rst_cout_rid", N'({cout, rid}), N'(0));
    do_reset();

    // Single request 3 + 10
    req0 = 1'b1; a0 = N'(3); b0 = N'(10);
    push(N'(13), 1'b0, 1'b0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("s1_gnt0", N'(gnt0), N'(1));
    chk("s1_gnt1", N'(gnt1), N'(0));
    chk("s1_busy", N'(busy), N'(1));
    tick();
    @(negedge clk);
    chk("s1_valid", N'(valid), N'(1));
    tick();
    @(negedge clk);
    chk("s1_valid_off", N'(valid), N'(0));
    chk("s1_idle", N'(busy), N'(0));
    chk("s1_y_hold", y, N'(13));

    // Tie after reset: requester 0 first, then 1, valids 3 cycles apart
    do_reset();
    vcyc.delete();
    req0 = 1'b1; a0 = N'(4);  b0 = N'(7);
    req1 = 1'b1; a1 = N'(15); b1 = N'(22);
    push(N'(11), 1'b0, 1'b0);
    push(N'(37), 1'b0, 1'b1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("s2_gnt0", N'(gnt0), N'(1));
    chk("s2_gnt1_lo", N'(gnt1), N'(0));
    tick();
    tick();
    @(negedge clk);
    chk("s2_gnt1_wait", N'(gnt1), N'(0));
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("s2_gnt1", N'(gnt1), N'(1));
    tick();
    tick();
    @(negedge clk);
    chk("s2_nvalid", N'(vcyc.size()), N'(2));
    if (vcyc.size() == 2) chk("s2_spacing", N'(vcyc[1] - vcyc[0]), N'(3));

    // Both held continuously: rid 0,1,0,1
    req0 = 1'b1; a0 = N'(100); b0 = N'(1);
    req1 = 1'b1; a1 = N'(200); b1 = N'(2);
    for (int i = 0; i < 4; i++) push(i[0] ? N'(202) : N'(101), 1'b0, i[0]);
    for (int i = 0; i < 10; i++) tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    tick();

    // Wrap-around on requester 1, and an all-ones sum that must not carry
    req1 = 1'b1; a1 = '1; b1 = N'(2);
    push(N'(1), 1'b1, 1'b1);
    tick();
    req1 = 1'b0;
    tick();
    tick();
    req0 = 1'b1; a0 = '1; b0 = N'(0);
    push('1, 1'b0, 1'b0);
    tick();
    req0 = 1'b0;
    tick();
    tick();

    // Reset during LOAD aborts the operation
    req0 = 1'b1; a0 = N'(5); b0 = N'(5);
    tick();
    req0 = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("s5_valid", N'(valid), N'(0));
    chk("s5_busy", N'(busy), N'(0));
    chk("s5_y", y, N'(0));
    tick();
    tick();
    tick();

    // Request arriving in OUT waits for IDLE
    req0 = 1'b1; a0 = N'(1); b0 = N'(1);
    push(N'(2), 1'b0, 1'b0);
    tick();
    req0 = 1'b0;
    tick();
    req1 = 1'b1; a1 = N'(2); b1 = N'(3);
    push(N'(5), 1'b0, 1'b1);
    @(negedge clk);
    chk("s6_out", N'(valid), N'(1));
    chk("s6_gnt1_out", N'(gnt1), N'(0));
    tick();
    @(negedge clk);
    chk("s6_gnt1_idle", N'(gnt1), N'(0));
    chk("s6_busy_idle", N'(busy), N'(0));
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("s6_gnt1", N'(gnt1), N'(1));
    tick();
    tick();
    tick();

    @(negedge clk);
    chk("sb_drain", N'(sb.size()), N'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
